// File: rtl/lane_packer.sv
// Packs LANE_W-bit lanes into LANES-wide words through a two-entry ping-pong
// buffer, emitting full or in_last-closed words with a per-lane keep mask.
module lane_packer #(
    parameter int LANE_W = 8,
    parameter int LANES  = 4,
    parameter int NBUF   = 2,
    localparam int WORD_W = LANES * LANE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LANE_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic [LANES-1:0]  out_keep,
    output logic              out_last
);

    localparam int LW = $clog2(LANES);
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);
    localparam logic [LANES-1:0] FIRST_KEEP = LANES'(1);

    logic                         wsel;
    logic                         rsel;
    logic [LW-1:0]                lane;
    logic [NBUF-1:0]              full;
    logic [NBUF-1:0]              last;
    logic [NBUF-1:0][LANES-1:0]   keep;
    logic [NBUF-1:0][WORD_W-1:0]  word_buf;

    logic accept;
    logic close;
    logic drain;

    assign in_ready  = !full[wsel];
    assign accept    = in_valid && in_ready;
    assign close     = accept && ((lane == LAST_LANE) || in_last);
    assign out_valid = full[rsel];
    assign drain     = out_valid && out_ready;
    assign out_keep  = keep[rsel];
    assign out_last  = last[rsel];

    // Fill and drain never target the same entry: a full entry blocks in_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wsel <= 1'b0;
            rsel <= 1'b0;
            lane <= '0;
            full <= '0;
            last <= '0;
            keep <= '0;
        end else begin
            if (accept) begin
                if (lane == '0)
                    keep[wsel] <= FIRST_KEEP;
                else
                    keep[wsel][lane] <= 1'b1;
                if (close) begin
                    full[wsel] <= 1'b1;
                    last[wsel] <= in_last;
                    wsel       <= ~wsel;
                    lane       <= '0;
                end else begin
                    lane <= lane + 1'b1;
                end
            end
            if (drain) begin
                full[rsel] <= 1'b0;
                rsel       <= ~rsel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            word_buf[wsel][lane*LANE_W +: LANE_W] <= in_data;
    end

    // Unkept lanes read as zero so stale bytes never leak out.
    always_comb begin
        out_data = '0;
        for (int k = 0; k < LANES; k++) begin
            if (keep[rsel][k])
                out_data[k*LANE_W +: LANE_W] = word_buf[rsel][k*LANE_W +: LANE_W];
        end
    end

endmodule

// File: tb/tb_lane_packer.sv
// Directed bench for lane_packer: reset, packing, backpressure and keep masks.
module tb_lane_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_last;

    int checks   = 0;
    int failures = 0;

    logic        cap = 1'b0;
    logic [31:0] q_data[$];
    logic [3:0]  q_keep[$];

    lane_packer #(.LANE_W(8), .LANES(4), .NBUF(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cap && out_valid && out_ready) begin
            q_data.push_back(out_data);
            q_keep.push_back(out_keep);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        chk("push_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_word(input string tag, input logic [31:0] d,
                            input logic [3:0] k, input logic l);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"}, out_data, d);
        chk({tag, "_keep"}, 32'(out_keep), 32'(k));
        chk({tag, "_last"}, 32'(out_last), 32'(l));
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_keep", 32'(out_keep), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_data", out_data, 32'd0);
        rst = 1'b0;
        tick();

        // Reset mid-word discards partial lanes
        push(8'h55, 1'b0);
        push(8'h66, 1'b0);
        rst = 1'b1;
        #2;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        tick();

        // Full word, one cycle after the 4th accept
        out_ready = 1'b1;
        push(8'h11, 1'b0);
        push(8'h22, 1'b0);
        push(8'h33, 1'b0);
        chk("full_not_early", 32'(out_valid), 32'd0);
        push(8'h44, 1'b0);
        chk_word("full", 32'h44332211, 4'hF, 1'b0);
        tick();
        chk("full_drained", 32'(out_valid), 32'd0);

        // Partial word closed by in_last
        push(8'hAA, 1'b0);
        push(8'hBB, 1'b1);
        chk_word("part", 32'h0000BBAA, 4'h3, 1'b1);
        tick();
        chk("part_drained", 32'(out_valid), 32'd0);

        // Backpressure: two words buffered, 9th lane stalls
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++)
            push(8'(i), 1'b0);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        chk_word("bp_w0", 32'h04030201, 4'hF, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h09;
        tick();
        chk("bp_stall_ready", 32'(in_ready), 32'd0);
        chk("bp_hold_data", out_data, 32'h04030201);
        out_ready = 1'b1;
        tick();
        chk("bp_ready_after_drain", 32'(in_ready), 32'd1);
        chk_word("bp_w1", 32'h08070605, 4'hF, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("bp_empty", 32'(out_valid), 32'd0);
        push(8'h0A, 1'b1);
        chk_word("bp_w2", 32'h00000A09, 4'h3, 1'b1);
        tick();

        // Sustained streaming, in_ready checked on every lane
        cap = 1'b1;
        for (int i = 0; i < 16; i++)
            push(8'(i), 1'b0);
        tick();
        tick();
        cap = 1'b0;
        chk("stream_count", 32'(q_data.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < q_data.size()) begin
                chk("stream_data", q_data[i], 32'h03020100 + 32'(i) * 32'h04040404);
                chk("stream_keep", 32'(q_keep[i]), 32'hF);
            end else begin
                chk("stream_missing", 32'(i), 32'hFFFFFFFF);
            end
        end

        // Keep masks never carry over between words in the same entry
        push(8'hEE, 1'b1);
        chk_word("k1", 32'h000000EE, 4'h1, 1'b1);
        push(8'hC1, 1'b0);
        push(8'hC2, 1'b0);
        push(8'hC3, 1'b0);
        push(8'hC4, 1'b0);
        chk_word("k2", 32'hC4C3C2C1, 4'hF, 1'b0);
        push(8'hD1, 1'b1);
        chk_word("k3", 32'h000000D1, 4'h1, 1'b1);
        push(8'hE1, 1'b0);
        push(8'hE2, 1'b1);
        chk_word("k4", 32'h0000E2E1, 4'h3, 1'b1);
        tick();
        chk("end_empty", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
